ysyx_22040895_dmem_resp: RTL and testbench

//   Data-memory responder on the far end of the core's memory-access interface.

---
 rtl/ysyx_22040895_dmem_resp.sv | 133 +++++++++++++
 tb/tb_ysyx_22040895_dmem_resp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_dmem_resp.sv
// Data-memory responder: byte-lane-masked 64-bit store with a fixed wait-state latency
// between request acceptance and the one-cycle completion pulse.
module ysyx_22040895_dmem_resp #(
  parameter int          DEPTH   = 512,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mce_i,
  input  logic        mwe_i,
  input  logic [1:0]  munit_i,
  input  logic [63:0] maddr_i,
  input  logic [63:0] wmdata_i,
  output logic [63:0] rmdata_o,
  output logic        mready_o,
  output logic        mbusy_o,
  output logic        mfault_o
);

  // Handshake: mce_i is a request strobe accepted only in IDLE; every accepted request
  // produces exactly one mready_o pulse (qualifying rmdata_o/mfault_o); mbusy_o spans the gap.
  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          we_q;
  logic [1:0]    unit_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rdata_q;
  logic          fault_q;
  logic [63:0]   mem [DEPTH];

  logic [63:0]   rel;
  logic [IW-1:0] idx;
  logic [2:0]    off;
  logic          misaligned;
  logic          in_range;
  logic          fault;
  logic [7:0]    size_mask;
  logic [7:0]    strobe;
  logic [63:0]   wdata_sh;
  logic [63:0]   rword_sh;
  logic [63:0]   load_val;
  logic          resp;

  assign rel      = addr_q - BASE;
  assign idx      = rel[IW+2:3];
  assign off      = addr_q[2:0];
  assign in_range = (addr_q >= BASE) && (rel < (64'(DEPTH) << 3));
  assign fault    = misaligned || !in_range;
  assign resp     = (state == RESP) && !rst;

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (unit_q)
      2'd0: begin misaligned = 1'b0;         size_mask = 8'h01; end
      2'd1: begin misaligned = off[0];       size_mask = 8'h03; end
      2'd2: begin misaligned = |off[1:0];    size_mask = 8'h0F; end
      default: begin misaligned = |off;      size_mask = 8'hFF; end
    endcase
  end

  assign strobe   = size_mask << off;
  assign wdata_sh = wdata_q << {off, 3'b000};
  assign rword_sh = mem[idx] >> {off, 3'b000};

  // Stores and faulted requests both return zero data.
  always_comb begin
    load_val = 64'd0;
    if (!we_q && !fault) begin
      case (unit_q)
        2'd0:    load_val = {56'd0, rword_sh[7:0]};
        2'd1:    load_val = {48'd0, rword_sh[15:0]};
        2'd2:    load_val = {32'd0, rword_sh[31:0]};
        default: load_val = rword_sh;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 64'd0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mce_i) begin
            we_q    <= mwe_i;
            unit_q  <= munit_i;
            addr_q  <= maddr_i;
            wdata_q <= wmdata_i;
            cnt     <= 4'(LATENCY - 1);
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          rdata_q <= load_val;
          fault_q <= fault;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The store contents survive reset; only a clean RESP cycle commits.
  always_ff @(posedge clk) begin
    if (resp && we_q && !fault) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign mready_o = resp;
  assign mbusy_o  = (state == WAIT) || (state == RESP);
  assign rmdata_o = resp ? load_val : rdata_q;
  assign mfault_o = resp ? fault : fault_q;

endmodule

// File: tb/tb_ysyx_22040895_dmem_resp.sv
// Bench for the data-memory responder: directed cases plus randomized loads/stores
// checked against a byte-addressed reference memory.
module tb_ysyx_22040895_dmem_resp;

  localparam int          DEPTH = 512;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LAT   = 2;
  localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mce = 1'b0;
  logic        mce1 = 1'b0;
  logic        mwe = 1'b0;
  logic [1:0]  munit = 2'd0;
  logic [63:0] maddr = 64'd0;
  logic [63:0] wmdata = 64'd0;
  logic [63:0] rmdata, rmdata1;
  logic        mready, mready1, mbusy, mbusy1, mfault, mfault1;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  mem_m [logic [63:0]];
  logic [63:0] exp_q [$];

  ysyx_22040895_dmem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .mce_i(mce), .mwe_i(mwe), .munit_i(munit),
    .maddr_i(maddr), .wmdata_i(wmdata), .rmdata_o(rmdata), .mready_o(mready),
    .mbusy_o(mbusy), .mfault_o(mfault)
  );

  ysyx_22040895_dmem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mce_i(mce1), .mwe_i(mwe), .munit_i(munit),
    .maddr_i(maddr), .wmdata_i(wmdata), .rmdata_o(rmdata1), .mready_o(mready1),
    .mbusy_o(mbusy1), .mfault_o(mfault1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // reference model: byte-addressed memory
  function automatic logic m_fault(input logic [1:0] u, input logic [63:0] a);
    logic [63:0] size;
    size = 64'd1 << u;
    return ((a % size) != 64'd0) || (a < BASE) || (a >= LIMIT);
  endfunction

  function automatic logic [63:0] m_load(input logic [1:0] u, input logic [63:0] a);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < (1 << u); i++)
      r[8*i +: 8] = mem_m.exists(a + 64'(i)) ? mem_m[a + 64'(i)] : 8'h00;
    return r;
  endfunction

  task automatic m_store(input logic [1:0] u, input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < (1 << u); i++) mem_m[a + 64'(i)] = d[8*i +: 8];
  endtask

  // driver: one request, returns response and latency in cycles
  task automatic do_req(input logic we, input logic [1:0] u, input logic [63:0] a,
                        input logic [63:0] d, output logic [63:0] rd,
                        output logic flt, output int lat);
    @(posedge clk); #1;
    mce = 1'b1; mwe = we; munit = u; maddr = a; wmdata = d;
    @(posedge clk); #1;
    mce = 1'b0;
    lat = 0; rd = 64'd0; flt = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mready) begin
        lat = c; rd = rmdata; flt = mfault;
        break;
      end
    end
  endtask

  task automatic op(input string tag, input logic we, input logic [1:0] u,
                    input logic [63:0] a, input logic [63:0] d);
    logic [63:0] rd, exp_d;
    logic flt, exp_f;
    int lat;
    do_req(we, u, a, d, rd, flt, lat);
    exp_f = m_fault(u, a);
    exp_d = (we || exp_f) ? 64'd0 : m_load(u, a);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_fault"}, 64'(flt), 64'(exp_f));
    check({tag, "_data"}, rd, exp_d);
    if (we && !exp_f) m_store(u, a, d);
  endtask

  initial begin
    logic [63:0] a, d;
    logic [1:0] u;
    logic we;
    int cyc, last, done, cnt;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rmdata", rmdata, 64'd0);
    check("rst_mready", 64'(mready), 64'd0);
    check("rst_mbusy", 64'(mbusy), 64'd0);
    check("rst_mfault", 64'(mfault), 64'd0);

    // initialize the words touched later so every load is defined
    for (int w = 0; w < 16; w++) op("init", 1'b1, 2'd3, BASE + 64'(w) * 8, {$urandom, $urandom});
    op("init_last", 1'b1, 2'd3, LIMIT - 64'd8, {$urandom, $urandom});

    // test 1 / 2: directed values
    op("sd0", 1'b1, 2'd3, BASE, 64'h1122334455667788);
    op("ld0", 1'b0, 2'd3, BASE, 64'd0);
    check("ld0_model", m_load(2'd3, BASE), 64'h1122334455667788);
    op("sb3", 1'b1, 2'd0, BASE + 64'd3, 64'h00000000000000AB);
    op("ld0b", 1'b0, 2'd3, BASE, 64'd0);
    check("ld0b_model", m_load(2'd3, BASE), 64'h11223344AB667788);
    op("lbu3", 1'b0, 2'd0, BASE + 64'd3, 64'd0);

    // test 3: cycle-exact timing, LATENCY=2
    @(posedge clk); #1;
    mce = 1'b1; mwe = 1'b0; munit = 2'd3; maddr = BASE;
    @(posedge clk); #1 mce = 1'b0;
    @(negedge clk);
    check("t3_busy_n1", 64'(mbusy), 64'd1);
    check("t3_ready_n1", 64'(mready), 64'd0);
    @(negedge clk);
    check("t3_busy_n2", 64'(mbusy), 64'd1);
    check("t3_ready_n2", 64'(mready), 64'd1);
    check("t3_data_n2", rmdata, 64'h11223344AB667788);
    @(negedge clk);
    check("t3_busy_n3", 64'(mbusy), 64'd0);
    check("t3_ready_n3", 64'(mready), 64'd0);
    check("t3_hold_n3", rmdata, 64'h11223344AB667788);

    // LATENCY=1 instance
    @(posedge clk); #1 mce1 = 1'b1;
    @(posedge clk); #1 mce1 = 1'b0;
    @(negedge clk);
    check("t3_l1_ready_n1", 64'(mready1), 64'd1);
    check("t3_l1_busy_n1", 64'(mbusy1), 64'd1);
    @(negedge clk);
    check("t3_l1_ready_n2", 64'(mready1), 64'd0);
    check("t3_l1_busy_n2", 64'(mbusy1), 64'd0);

    // test 4: faults
    op("sh_mis", 1'b1, 2'd1, BASE + 64'd1, 64'h0000_0000_0000_BEEF);
    op("ld_after_mis", 1'b0, 2'd3, BASE, 64'd0);
    op("ld_oor", 1'b0, 2'd3, BASE + 64'h1000, 64'd0);
    op("ld_below", 1'b0, 2'd3, 64'h7FFF_FFF8, 64'd0);

    // test 5: reset during WAIT aborts a store
    @(posedge clk); #1;
    mce = 1'b1; mwe = 1'b1; munit = 2'd3; maddr = BASE + 64'd8; wmdata = '1;
    @(posedge clk); #1;
    mce = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (mready) cnt++;
    end
    check("t5_no_ready", 64'(cnt), 64'd0);
    check("t5_busy", 64'(mbusy), 64'd0);
    op("t5_ld", 1'b0, 2'd3, BASE + 64'd8, 64'd0);

    // test 6: mce held high, alternating addresses
    @(posedge clk); #1;
    mce = 1'b1; mwe = 1'b0; munit = 2'd3; maddr = BASE + 64'd16;
    exp_q.push_back(m_load(2'd3, maddr));
    cyc = 0; last = -1; done = 0;
    while (done < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mready) begin
        check("b2b_data", rmdata, exp_q.pop_front());
        if (last >= 0) check("b2b_gap", 64'(cyc - last), 64'(LAT + 1));
        last = cyc;
        done++;
        if (done < 6) begin
          maddr = (done % 2 == 1) ? BASE + 64'd24 : BASE + 64'd16;
          exp_q.push_back(m_load(2'd3, maddr));
        end else begin
          mce = 1'b0;
        end
      end
    end
    check("b2b_count", 64'(done), 64'd6);
    check("b2b_qempty", 64'(exp_q.size()), 64'd0);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      u  = 2'($urandom_range(0, 3));
      a  = BASE + 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
      d  = {$urandom, $urandom};
      case ($urandom_range(0, 11))
        0: a = BASE - 64'd8;
        1: a = LIMIT;
        2: a = LIMIT - 64'd8 + 64'($urandom_range(0, 7));
        default: ;
      endcase
      op("rand", we, u, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
